// File: rtl/elg_pkg.sv
// Shared constants and types for the ElGamal decrypt stream sequencer.
//   P_SECP256K1 : secp256k1 field prime; every coordinate must be below it
//   WORDS_IN    : 32-bit words per input frame (Cx, Cy, Dx, Dy, priv)
//   WORDS_OUT   : 32-bit words per result frame (outx, outy)
//   state_t     : sequencer FSM states
//   err_code_t  : encodings driven on err_code
package elg_pkg;

    localparam logic [255:0] P_SECP256K1 =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    localparam int WORDS_IN  = 40;
    localparam int WORDS_OUT = 16;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_RANGE    = 2'b01,
        ERR_ZERO_KEY = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } err_code_t;

endpackage

// File: rtl/elg_range_check.sv
// Combinational operand screen for the decrypt core.
//   coord     : NUM_LANES 256-bit coordinates, each must be < P
//   priv      : private key, must be non-zero
//   range_err : some coordinate is >= P
//   zero_err  : priv is zero
module elg_range_check
    import elg_pkg::*;
#(
    parameter logic [255:0] P         = P_SECP256K1,
    parameter int           NUM_LANES = 4
) (
    input  logic [NUM_LANES-1:0][255:0] coord,
    input  logic [255:0]                priv,
    output logic                        range_err,
    output logic                        zero_err
);

    logic [NUM_LANES-1:0] ge_p;

    // One magnitude comparator per coordinate.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign ge_p[i] = (coord[i] >= P);
    end

    assign range_err = |ge_p;
    assign zero_err  = (priv == '0);

endmodule

// File: rtl/elg_dec_sequencer.sv
// Stream front/back end for the ElGamal decrypt core.
//   Clk, Reset_n             : clock, async active-low reset
//   in_data/valid/ready      : 40-word input frame (Cx, Cy, Dx, Dy, priv, MSW first)
//   out_data/valid/ready     : 16-word result frame (outx, outy, MSW first)
//   core_reset               : active-high reset to the core, low only in RUN
//   Cx, Cy, Dx, Dy, priv     : registered operands to the core
//   core_done, core_outx/y   : core completion and result point
//   err_valid, err_code      : one-cycle error pulse, code held until next error
//   busy                     : high in CHECK, RUN and DRAIN
module elg_dec_sequencer
    import elg_pkg::*;
#(
    parameter logic [255:0] P          = P_SECP256K1,
    parameter logic [23:0]  MAX_CYCLES = 24'hFFFFFF
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [31:0]  out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         core_reset,
    output logic [255:0] Cx,
    output logic [255:0] Cy,
    output logic [255:0] Dx,
    output logic [255:0] Dy,
    output logic [255:0] priv,
    input  logic         core_done,
    input  logic [255:0] core_outx,
    input  logic [255:0] core_outy,
    output logic         err_valid,
    output logic [1:0]   err_code,
    output logic         busy
);

    state_t          state;
    logic [5:0]      wcnt;     // input word index in LOAD, output word index in DRAIN
    logic [23:0]     ccnt;     // RUN watchdog
    logic [1279:0]   in_sr;
    logic [511:0]    out_sr;
    logic            range_err;
    logic            zero_err;

    // Operands are views of the input shift register, so they only move on a LOAD accept.
    assign Cx   = in_sr[1279:1024];
    assign Cy   = in_sr[1023:768];
    assign Dx   = in_sr[767:512];
    assign Dy   = in_sr[511:256];
    assign priv = in_sr[255:0];

    assign out_data = out_sr[511:480];

    elg_range_check #(.P(P), .NUM_LANES(4)) u_range_check (
        .coord     ({Cx, Cy, Dx, Dy}),
        .priv      (priv),
        .range_err (range_err),
        .zero_err  (zero_err)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= LOAD;
            wcnt       <= '0;
            ccnt       <= '0;
            in_sr      <= '0;
            out_sr     <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            core_reset <= 1'b1;
            err_valid  <= 1'b0;
            err_code   <= ERR_NONE;
            busy       <= 1'b0;
        end else begin
            err_valid <= 1'b0;
            case (state)
                LOAD: begin
                    // in_ready rises on the first edge after reset release.
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_sr <= {in_sr[1247:0], in_data};
                        if (wcnt == 6'(WORDS_IN - 1)) begin
                            wcnt     <= '0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                            state    <= CHECK;
                        end else begin
                            wcnt <= wcnt + 6'd1;
                        end
                    end
                end
                CHECK: begin
                    // Range error takes priority over the zero-key error.
                    if (range_err || zero_err) begin
                        err_code  <= range_err ? ERR_RANGE : ERR_ZERO_KEY;
                        err_valid <= 1'b1;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= LOAD;
                    end else begin
                        ccnt       <= '0;
                        core_reset <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    ccnt <= ccnt + 24'd1;
                    if (core_done) begin
                        out_sr     <= {core_outx, core_outy};
                        out_valid  <= 1'b1;
                        core_reset <= 1'b1;
                        state      <= DRAIN;
                    end else if (ccnt == MAX_CYCLES - 24'd1) begin
                        err_code   <= ERR_TIMEOUT;
                        err_valid  <= 1'b1;
                        core_reset <= 1'b1;
                        in_ready   <= 1'b1;
                        busy       <= 1'b0;
                        state      <= LOAD;
                    end
                end
                default: begin // DRAIN
                    if (out_ready) begin
                        out_sr <= {out_sr[479:0], 32'h0};
                        if (wcnt == 6'(WORDS_OUT - 1)) begin
                            wcnt      <= '0;
                            out_valid <= 1'b0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                            state     <= LOAD;
                        end else begin
                            wcnt <= wcnt + 6'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elg_dec_sequencer.sv
module tb_elg_dec_sequencer;
    import elg_pkg::*;

    logic         Clk = 1'b0;
    logic         Reset_n;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         out_ready;
    logic         core_done;
    logic [255:0] core_outx, core_outy;

    logic         in_ready, out_valid, core_reset, err_valid, busy;
    logic [31:0]  out_data;
    logic [1:0]   err_code;
    logic [255:0] Cx, Cy, Dx, Dy, priv;

    logic         w_in_ready, w_out_valid, w_core_reset, w_err_valid, w_busy;
    logic [31:0]  w_out_data;
    logic [1:0]   w_err_code;
    logic [255:0] w_Cx, w_Cy, w_Dx, w_Dy, w_priv;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    elg_dec_sequencer dut (
        .Clk(Clk), .Reset_n(Reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .core_reset(core_reset), .Cx(Cx), .Cy(Cy),
        .Dx(Dx), .Dy(Dy), .priv(priv), .core_done(core_done),
        .core_outx(core_outx), .core_outy(core_outy), .err_valid(err_valid),
        .err_code(err_code), .busy(busy)
    );

    // Second instance with a short watchdog, only examined in the timeout scenario.
    elg_dec_sequencer #(.MAX_CYCLES(24'd16)) dut_wd (
        .Clk(Clk), .Reset_n(Reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(w_in_ready), .out_data(w_out_data), .out_valid(w_out_valid),
        .out_ready(out_ready), .core_reset(w_core_reset), .Cx(w_Cx), .Cy(w_Cy),
        .Dx(w_Dx), .Dy(w_Dy), .priv(w_priv), .core_done(core_done),
        .core_outx(core_outx), .core_outy(core_outy), .err_valid(w_err_valid),
        .err_code(w_err_code), .busy(w_busy)
    );

    // Core model: done rises after done_after cycles out of reset.
    int done_after = 100;
    bit done_en    = 1'b0;
    int low_cnt    = 0;
    always @(posedge Clk) low_cnt <= core_reset ? 0 : low_cnt + 1;
    assign core_done = done_en && !core_reset && (low_cnt == done_after);

    int errv_cnt = 0;
    always @(negedge Clk) if (err_valid === 1'b1) errv_cnt <= errv_cnt + 1;

    logic [255:0] fr [5];
    logic [1:0]   last_code = 2'b00;

    localparam logic [255:0] GX  = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    localparam logic [255:0] GY  = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
    localparam logic [255:0] G2X = 256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
    localparam logic [255:0] G2Y = 256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
        return r;
    endfunction

    function automatic logic [31:0] out_word(input logic [511:0] v, input int i);
        logic [511:0] s;
        s = v >> (32 * (15 - i));
        return s[31:0];
    endfunction

    function automatic logic [31:0] in_word(input int w);
        logic [255:0] s;
        s = fr[w / 8] >> (32 * (7 - (w % 8)));
        return s[31:0];
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic send_frame(input int nwords, input bit gaps);
        bit acc;
        int cyc;
        for (int w = 0; w < nwords; w++) begin
            acc = 1'b0;
            cyc = 0;
            while (!acc && cyc < 200) begin
                in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                in_data  = in_valid ? in_word(w) : $urandom;
                acc      = in_valid && in_ready;
                step();
                cyc++;
            end
            if (!acc) begin
                checks++; errors++;
                $display("FAIL send_word w=%0d: no accept within 200 cycles, required accept", w);
            end
        end
        in_valid = 1'b0;
    endtask

    // Drives the frame in fr[], models the expected outcome and checks it.
    task automatic run_frame(input string tag, input bit gaps, input bit rnd_ready, input int abort_at);
        int           exp_err, e0, low, got, cyc;
        bit           stalled, rdy;
        logic [31:0]  held;
        logic [31:0]  rx [16];
        logic [511:0] res;

        if (fr[0] >= P_SECP256K1 || fr[1] >= P_SECP256K1 ||
            fr[2] >= P_SECP256K1 || fr[3] >= P_SECP256K1) exp_err = 1;
        else if (fr[4] == '0) exp_err = 2;
        else exp_err = 0;
        e0 = errv_cnt;
        res = {core_outx, core_outy};

        send_frame(40, gaps);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1 || core_reset !== 1'b1)
            begin errors++; $display("FAIL %s check_cycle: in_ready=%b busy=%b core_reset=%b, required 0 1 1", tag, in_ready, busy, core_reset); end
        checks++;
        if (Cx !== fr[0] || Cy !== fr[1] || Dx !== fr[2] || Dy !== fr[3] || priv !== fr[4])
            begin errors++; $display("FAIL %s operands: Cx=%h priv=%h, required Cx=%h priv=%h", tag, Cx, priv, fr[0], fr[4]); end
        step();

        if (exp_err != 0) begin
            last_code = exp_err[1:0];
            checks++;
            if (err_valid !== 1'b1 || err_code !== last_code)
                begin errors++; $display("FAIL %s err_pulse: err_valid=%b err_code=%b, required 1 %b", tag, err_valid, err_code, last_code); end
            checks++;
            if (in_ready !== 1'b1 || core_reset !== 1'b1 || busy !== 1'b0)
                begin errors++; $display("FAIL %s after_err: in_ready=%b core_reset=%b busy=%b, required 1 1 0", tag, in_ready, core_reset, busy); end
            step();
            checks++;
            if (err_valid !== 1'b0 || errv_cnt - e0 != 1)
                begin errors++; $display("FAIL %s err_width: err_valid=%b pulses=%0d, required 0 1", tag, err_valid, errv_cnt - e0); end
            return;
        end

        low = 0;
        while (core_reset === 1'b0 && low < 1000) begin low++; step(); end
        checks++;
        if (low != done_after + 1)
            begin errors++; $display("FAIL %s core_reset_low: %0d cycles, required %0d", tag, low, done_after + 1); end

        got = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (got < 16 && cyc < 2000) begin
            if (abort_at >= 0 && got >= abort_at) begin out_ready = 1'b0; return; end
            rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rdy;
            checks++;
            if (out_valid !== 1'b1)
                begin errors++; $display("FAIL %s drain_valid: out_valid=%b after %0d words, required 1", tag, out_valid, got); end
            if (stalled) begin
                checks++;
                if (out_data !== held)
                    begin errors++; $display("FAIL %s stall_hold: out_data=%h, required %h", tag, out_data, held); end
            end
            if (out_valid === 1'b1 && rdy) begin
                rx[got] = out_data; got++; stalled = 1'b0;
            end else begin
                stalled = (out_valid === 1'b1); held = out_data;
            end
            step();
            cyc++;
        end
        out_ready = 1'b0;
        checks++;
        if (got != 16)
            begin errors++; $display("FAIL %s drain_count: %0d words, required 16", tag, got); end
        for (int i = 0; i < got; i++) begin
            checks++;
            if (rx[i] !== out_word(res, i))
                begin errors++; $display("FAIL %s out_word[%0d]: %h, required %h", tag, i, rx[i], out_word(res, i)); end
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || core_reset !== 1'b1)
            begin errors++; $display("FAIL %s after_drain: out_valid=%b in_ready=%b busy=%b core_reset=%b, required 0 1 0 1", tag, out_valid, in_ready, busy, core_reset); end
        checks++;
        if (errv_cnt != e0 || err_code !== last_code)
            begin errors++; $display("FAIL %s no_err: pulses=%0d err_code=%b, required 0 %b", tag, errv_cnt - e0, err_code, last_code); end
    endtask

    // Asserts Reset_n mid-cycle, checks asynchronous reset values, then releases.
    task automatic apply_reset(input string tag);
        #2;
        Reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        last_code = 2'b00;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0 || core_reset !== 1'b1 ||
            busy !== 1'b0 || err_valid !== 1'b0 || err_code !== 2'b00)
            begin errors++; $display("FAIL %s reset_ctrl: in_ready=%b out_valid=%b out_data=%h core_reset=%b busy=%b err_valid=%b err_code=%b", tag, in_ready, out_valid, out_data, core_reset, busy, err_valid, err_code); end
        checks++;
        if (Cx !== '0 || Cy !== '0 || Dx !== '0 || Dy !== '0 || priv !== '0)
            begin errors++; $display("FAIL %s reset_operands: Cx=%h priv=%h, required 0", tag, Cx, priv); end
        repeat (2) @(posedge Clk);
        #3;
        Reset_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || core_reset !== 1'b1)
            begin errors++; $display("FAIL %s post_reset: in_ready=%b busy=%b core_reset=%b, required 1 0 1", tag, in_ready, busy, core_reset); end
    endtask

    task automatic load_valid_g();
        fr[0] = GX; fr[1] = GY; fr[2] = G2X; fr[3] = G2Y; fr[4] = 256'd1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        core_outx = '0; core_outy = '0;
        repeat (2) @(posedge Clk);
        #1;
        apply_reset("reset");
    endtask

    task automatic test_known_vector();
        load_valid_g();
        core_outx = 256'h1234; core_outy = 256'h5678;
        done_after = 100; done_en = 1'b1;
        run_frame("known", 1'b0, 1'b0, -1);
    endtask

    task automatic test_errors();
        load_valid_g(); fr[0] = P_SECP256K1;
        run_frame("cx_eq_p", 1'b0, 1'b0, -1);
        load_valid_g(); fr[4] = '0;
        run_frame("zero_key", 1'b0, 1'b0, -1);
        load_valid_g(); fr[1] = P_SECP256K1; fr[4] = '0;
        run_frame("range_and_zero", 1'b0, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < 4; k++) begin
                fr[k] = rnd256();
                if ($urandom_range(0, 7) == 0) fr[k] = P_SECP256K1 + 256'($urandom_range(0, 1000));
            end
            fr[4] = ($urandom_range(0, 5) == 0) ? 256'd0 : rnd256();
            core_outx  = rnd256();
            core_outy  = rnd256();
            done_after = $urandom_range(0, 40);
            run_frame("random", 1'b1, 1'b1, -1);
        end
    endtask

    task automatic test_abort();
        load_valid_g();
        send_frame(20, 1'b1);
        apply_reset("abort_load");
        core_outx = rnd256(); core_outy = rnd256(); done_after = 10;
        run_frame("abort_drain", 1'b0, 1'b1, 6);
        apply_reset("abort_drain");
        core_outx = rnd256(); core_outy = rnd256(); done_after = 7;
        run_frame("after_abort", 1'b1, 1'b1, -1);
    endtask

    task automatic test_timeout();
        int low;
        apply_reset("pre_timeout");
        done_en = 1'b0;
        load_valid_g();
        send_frame(40, 1'b0);
        checks++;
        if (w_in_ready !== 1'b0 || w_busy !== 1'b1)
            begin errors++; $display("FAIL timeout load: in_ready=%b busy=%b, required 0 1", w_in_ready, w_busy); end
        step();
        low = 0;
        while (w_core_reset === 1'b0 && low < 100) begin low++; step(); end
        checks++;
        if (low != 16)
            begin errors++; $display("FAIL timeout run_len: %0d cycles, required 16", low); end
        checks++;
        if (w_err_valid !== 1'b1 || w_err_code !== 2'b11 || w_in_ready !== 1'b1 || w_busy !== 1'b0)
            begin errors++; $display("FAIL timeout err: err_valid=%b err_code=%b in_ready=%b busy=%b, required 1 11 1 0", w_err_valid, w_err_code, w_in_ready, w_busy); end
        step();
        checks++;
        if (w_err_valid !== 1'b0 || w_err_code !== 2'b11 || w_core_reset !== 1'b1)
            begin errors++; $display("FAIL timeout after: err_valid=%b err_code=%b core_reset=%b, required 0 11 1", w_err_valid, w_err_code, w_core_reset); end
        apply_reset("post_timeout");
    endtask

    initial begin
        test_reset();
        test_known_vector();
        test_errors();
        test_back_to_back();
        test_abort();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule

// File: doc/elg_dec_sequencer.md
Name: elg_dec_sequencer

Overview:
- Stream-side front/back end for the ElGamal decrypt core over secp256k1.
- Collects a ciphertext (C1, C2) and private key as 32-bit words over a valid/ready handshake, then range-checks the operands.
- Releases the decrypt core from reset, waits for its Done, captures the recovered message point, and streams it back out as 32-bit words.
- Sits directly upstream and downstream of the decrypt core and owns that core's Reset.

Parameters:
- P, 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F, field prime; coordinates must be < P.
- MAX_CYCLES, 24'hFFFFFF, RUN-state watchdog limit in clock cycles.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- in_data  in  32  ciphertext/key word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  sequencer accepts a word this cycle.
- out_data  out  32  result word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- core_reset  out  1  active-high reset to the decrypt core.
- Cx, Cy, Dx, Dy  out  256 each  registered operands to the core.
- priv  out  256  registered private key to the core.
- core_done  in  1  core Done.
- core_outx, core_outy  in  256 each  core result point.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  2  error code: 01 coordinate >= P, 10 priv == 0, 11 watchdog timeout; held until next error.
- busy  out  1  high in CHECK, RUN and DRAIN.

Behaviour:
- Reset (async assert, sync release) sets these values:
  - state = LOAD, word counter = 0, cycle counter = 0.
  - in_ready = 0 while Reset_n is low, then 1 in LOAD.
  - out_valid = 0, out_data = 0.
  - core_reset = 1.
  - operand registers = 0.
  - err_valid = 0, err_code = 00.
  - busy = 0.
- LOAD:
  - in_ready = 1; a word is accepted on each edge with in_valid && in_ready.
  - 40 words arrive in order: Cx, Cy, Dx, Dy, priv, 8 words each, most-significant word first.
  - Storage is a 1280-bit shift register: each accept shifts left by 32 and inserts in_data in the low bits.
  - On accepting word 40 (counter 39 -> 0), go to CHECK. in_ready falls the next cycle.
- CHECK (exactly 1 cycle):
  - If any of Cx, Cy, Dx, Dy >= P: err_code = 01, pulse err_valid, go to LOAD.
  - Else if priv == 0: err_code = 10, pulse err_valid, go to LOAD.
  - Else go to RUN.
  - When both conditions hold, the range error wins.
- RUN:
  - core_reset = 0 for the whole state; the first deasserted cycle is the cycle after CHECK.
  - The cycle counter increments every cycle.
  - core_done is sampled only in RUN. When it is seen high, latch {core_outx, core_outy} into a 512-bit output shift register, assert core_reset the next cycle, and go to DRAIN.
  - If the counter reaches MAX_CYCLES before done: err_code = 11, pulse err_valid, assert core_reset, go to LOAD.
- DRAIN:
  - out_valid = 1. out_data = top 32 bits of the output register; outx MSW first, then outy, 16 words total.
  - out_data is stable while out_valid && !out_ready.
  - On each out_valid && out_ready, shift the register left by 32.
  - After the 16th accept, out_valid falls next cycle and the state returns to LOAD.
- core_reset is 1 in every state except RUN.
- Operand outputs hold their value until the next LOAD shift.
- Inputs are ignored outside LOAD: in_ready = 0.
- Reset_n asserted in any state aborts immediately:
  - partial frames and results are discarded;
  - core_reset = 1 asynchronously;
  - no err_valid pulse.
- Back-to-back frames: the first word of the next frame is accepted at the earliest 1 cycle after the final DRAIN handshake.

Decomposition:
- Package elg_pkg holds:
  - P_SECP256K1 constant;
  - WORDS_IN = 40, WORDS_OUT = 16;
  - state enum {LOAD, CHECK, RUN, DRAIN};
  - err_code enum {ERR_NONE, ERR_RANGE, ERR_ZERO_KEY, ERR_TIMEOUT}.
- One sub-module, elg_range_check: combinational check of four 256-bit values against P plus a priv-zero detect. It returns range_err and zero_err.

Test Plan:
- Frame with Cx=Gx=79BE667E..16F81798, Cy=Gy=483ADA77..FB10D4B8, Dx=Dy of 2G, priv=1; core model asserts done after 100 RUN cycles with outx=256'h1234, outy=256'h5678 -> 16 output words: 7 zeros, 0x00001234, 7 zeros, 0x00005678. core_reset low exactly 101 cycles, err_valid never asserted.
- Cx = P (...FFFFFC2F) in an otherwise valid frame -> err_valid pulse 1 cycle after word 40, err_code=01, core_reset stays 1, in_ready=1 again next cycle.
- Valid coordinates with priv=0 -> err_code=10. Cy=P and priv=0 together -> err_code=01.
- Random out_ready (50%) during DRAIN and random in_valid gaps during LOAD -> no lost or duplicated words; out_data constant while stalled.
- MAX_CYCLES overridden to 16, core never asserts done -> err_code=11 after 16 RUN cycles, core_reset=1, return to LOAD.
- Reset_n pulsed low after word 20 and again mid-DRAIN -> all outputs at reset values. A following full valid frame completes normally.
